// File: rtl/pc_branch_unit.sv
// Program-counter and branch unit: decodes move vs. control ops, steps or redirects
// the PC, maintains a LIFO return stack and the output-pin source select.
module pc_branch_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2*ADDR_W-1:0]   addrs,
  input  logic [DATA_W-1:0]     dIn0,
  input  logic [DATA_W-1:0]     offset,
  input  logic                  carry_flag,
  input  logic                  borrow_flag,
  output logic [DATA_W-1:0]     pc,
  output logic                  mov_we,
  output logic [ADDR_W-1:0]     mov_dst,
  output logic [DATA_W-1:0]     mov_data,
  output logic [DATA_W-1:0]     pins_out,
  output logic                  out_sel,
  output logic                  flush,
  output logic                  stack_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] dst, src;
  logic              eq;
  logic [7:0]        op;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic              out_sel_q, out_sel_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] stack_q [SLOTS];
  logic              push;

  logic [DATA_W-1:0] pc_inc, pc_tgt;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              full, empty;

  assign dst = addrs[2*ADDR_W-1:ADDR_W];
  assign src = addrs[ADDR_W-1:0];
  assign eq  = (dst == src);
  // Zero-extend so op codes above the field range never alias small codes.
  assign op  = 8'(dst);

  assign mov_we   = enable & ~eq;
  assign mov_dst  = dst;
  assign mov_data = enable ? dIn0 : '0;

  // Two's-complement offset: modular addition gives the signed displacement.
  assign pc_inc = pc_q + DATA_W'(1);
  assign pc_tgt = pc_q + offset;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign wr_idx = IDX_W'(cnt_q);
  assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));

  always_comb begin
    pc_d      = pc_q;
    out_sel_d = out_sel_q;
    flush_d   = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    if (enable) begin
      pc_d = pc_inc;
      if (eq) begin
        case (op)
          8'd0: if (carry_flag)  begin pc_d = pc_tgt; flush_d = 1'b1; end
          8'd1: if (borrow_flag) begin pc_d = pc_tgt; flush_d = 1'b1; end
          8'd2: begin pc_d = pc_tgt; flush_d = 1'b1; end
          8'd3: out_sel_d = ~out_sel_q;
          8'd4: begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              push    = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              pc_d    = pc_tgt;
              flush_d = 1'b1;
            end
          end
          8'd5: begin
            if (empty) begin
              err_d = 1'b1;
            end else begin
              cnt_d   = cnt_q - CNT_W'(1);
              pc_d    = stack_q[rd_idx];
              flush_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      out_sel_q <= 1'b0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      out_sel_q <= out_sel_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Stack storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= pc_inc;
  end

  assign pc        = pc_q;
  assign out_sel   = out_sel_q;
  assign flush     = flush_q;
  assign stack_err = err_q;
  assign pins_out  = out_sel_q ? pc_q : offset;

endmodule
